bp_protocol_monitor: RTL and testbench
======================================

BP_PROTOCOL_MONITOR -- requirements
Module: bp_protocol_monitor

Interface
REQ-001 Parameter PC_W, 10, PC width.
REQ-002 Parameter LHT_W, 10, local-history result width.
REQ-003 Parameter PH_W, 12, path-history result width.
REQ-004 Parameter PC_HOLD, 8, minimum cycles PC holds after a change (2..255).
REQ-005 Parameter LHT_LAT / LP_LAT / PRED_LAT, 1 / 2 / 2, cycles after a PC change at which the result must be known (1..PC_HOLD).
REQ-006 Parameter PH_HOLD, 2, minimum cycles PHresult holds after a change.
REQ-007 Parameter SLOW_LO, 2, exact slowclock low time in clock cycles.
REQ-008 Parameter CNT_W, 8, error counter width.
REQ-009 clock  in  1  single clock; all logic on posedge clock.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 mon_en  in  1  check enable; 0 suppresses error detection only.
REQ-012 err_clear  in  1  synchronous clear of sticky/count/capture state.
REQ-013 PC  in  PC_W; slowclock  in  1; LHTresult  in  LHT_W; LPresult, PredictedBranch  in  1; PHresult  in  PH_W.
REQ-014 err_pulse  out  6  per-check violation, registered, one cycle per violation.
REQ-015 err_sticky  out  6; err_any  out  1 (OR of err_sticky); err_count  out  CNT_W.
REQ-016 first_err_vec  out  6; first_err_pc  out  PC_W: capture of first violation.

Function
REQ-017 Bit map: [0] PC stability, [1] LHT known, [2] LP known, [3] Predicted known, [4] PH stability, [5] slowclock low time.
REQ-018 PC change = PC differs from registered pc_q while pc_vld=1; pc_vld sets on the first cycle after reset, so no change is detected on that cycle.
REQ-019 PC window FSM: IDLE -> HOLD on PC change with wcnt=1; wcnt increments each cycle, saturating at PC_HOLD; HOLD -> IDLE when wcnt reaches PC_HOLD.
REQ-020 A PC change in HOLD with wcnt<PC_HOLD sets bit 0 and restarts HOLD with wcnt=1; pending known-checks of the old window are discarded.
REQ-021 In HOLD at wcnt==LHT_LAT/LP_LAT/PRED_LAT, an unknown value of the matching signal sets bit 1/2/3.
REQ-022 Unknown = reduction-XOR of the vector is X or Z (simulation semantics); in synthesis the signal is treated as known.
REQ-023 PH FSM is the same as the PC window FSM, with PH_HOLD as the hold time; a PH change before the hold time elapses sets bit 4.
REQ-024 Slowclock FSM: HIGH -> LOW on fall, lcnt=1. In LOW, lcnt increments each cycle. A rise with lcnt!=SLOW_LO sets bit 5. Reaching lcnt==SLOW_LO without a rise also sets bit 5 once, and the FSM goes to WAIT until the next rise.
REQ-025 Detection in cycle N drives err_pulse in cycle N+1; multiple bits may assert in the same cycle.
REQ-026 err_sticky |= err_pulse each cycle.
REQ-027 err_count increments by 1 per cycle with any err_pulse bit set, saturating at all-ones.
REQ-028 first_err_vec/first_err_pc load err_pulse and the PC of the violating cycle only while first_err_vec==0.
REQ-029 err_clear in the same cycle as an err_pulse: the clear applies first, then the new pulse is recorded (sticky = pulse, count = 1, capture loads).
REQ-030 mon_en=0: err_pulse is forced to 0; FSMs and counters keep tracking, so checks resume with correct timing.

Reset
REQ-031 reset forces all outputs to 0, all FSMs to IDLE/HIGH, wcnt=lcnt=0, pc_vld=0, and takes priority over err_clear.
REQ-032 reset mid-window abandons the window; no error is reported for it.

Configuration
REQ-033 Macro BPMON_PER_CHECK_CNT_EN defined: an additional output chk_count (6*CNT_W, saturating per-bit counters, cleared by reset/err_clear) is present; undefined: the port and counters are absent, all other behaviour is identical.

Verification
REQ-034 PC 0x010 held 8 cycles, then 0x020 -> err_pulse stays 0, err_count=0.
REQ-035 PC changes 0x010 -> 0x011 at wcnt=3 -> err_pulse=6'b000001 for one cycle, first_err_pc=0x011, err_count=1.
REQ-036 LPresult=X at wcnt=2 and PredictedBranch=X at wcnt=2 -> err_pulse=6'b001100 in a single cycle, err_count=1.
REQ-037 slowclock low for 3 cycles with SLOW_LO=2 -> bit 5 pulses once at lcnt==2; no second pulse at the rise.
REQ-038 err_clear in the same cycle as a bit-4 pulse -> err_sticky=6'b010000, err_count=1, first_err_vec=6'b010000.
REQ-039 255 consecutive violations with CNT_W=8 -> err_count holds 0xFF; reset asserted mid-window -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/bp_protocol_monitor.sv
`default_nettype none
// ============================================================================
// Module   : bp_protocol_monitor
// Brief    : Checks branch-predictor PC, result, PH and slowclock timing.
//            Optional per-check counters are enabled by BPMON_PER_CHECK_CNT_EN.
// Revision : 1.0
// ============================================================================
module bp_protocol_monitor #(
    parameter int PC_W     = 10,
    parameter int LHT_W    = 10,
    parameter int PH_W     = 12,
    parameter int PC_HOLD  = 8,
    parameter int LHT_LAT  = 1,
    parameter int LP_LAT   = 2,
    parameter int PRED_LAT = 2,
    parameter int PH_HOLD  = 2,
    parameter int SLOW_LO  = 2,
    parameter int CNT_W    = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mon_en,
    input  logic               err_clear,
    input  logic [PC_W-1:0]    PC,
    input  logic               slowclock,
    input  logic [LHT_W-1:0]   LHTresult,
    input  logic               LPresult,
    input  logic               PredictedBranch,
    input  logic [PH_W-1:0]    PHresult,
    output logic [5:0]         err_pulse,
    output logic [5:0]         err_sticky,
    output logic               err_any,
    output logic [CNT_W-1:0]   err_count,
    output logic [5:0]         first_err_vec,
    output logic [PC_W-1:0]    first_err_pc
`ifdef BPMON_PER_CHECK_CNT_EN
    ,
    output logic [6*CNT_W-1:0] chk_count
`endif
);

    localparam logic [0:0] c_win_idle = 1'b0;
    localparam logic [0:0] c_win_hold = 1'b1;
    localparam logic [1:0] c_sc_high  = 2'd0;
    localparam logic [1:0] c_sc_low   = 2'd1;
    localparam logic [1:0] c_sc_wait  = 2'd2;

    localparam logic [7:0] c_pc_hold  = 8'(PC_HOLD);
    localparam logic [7:0] c_ph_hold  = 8'(PH_HOLD);
    localparam logic [7:0] c_lht_lat  = 8'(LHT_LAT);
    localparam logic [7:0] c_lp_lat   = 8'(LP_LAT);
    localparam logic [7:0] c_pred_lat = 8'(PRED_LAT);
    localparam logic [7:0] c_slow_lo  = 8'(SLOW_LO);

    logic              r_vld;
    logic [PC_W-1:0]   r_pc_q;
    logic [PH_W-1:0]   r_ph_q;
    logic              r_sc_q;
    logic [0:0]        r_win_st;
    logic [7:0]        r_wcnt;
    logic [0:0]        r_ph_st;
    logic [7:0]        r_phcnt;
    logic [1:0]        r_sc_st;
    logic [7:0]        r_lcnt;
    logic [PC_W-1:0]   r_pulse_pc;

    logic              w_pc_chg;
    logic              w_ph_chg;
    logic              w_fall;
    logic              w_rise;
    logic              w_lht_unk;
    logic              w_lp_unk;
    logic              w_pred_unk;
    logic [5:0]        w_det;

    // Unknown detection is a simulation-only notion; hardware sees known values.
`ifdef SYNTHESIS
    assign w_lht_unk  = 1'b0;
    assign w_lp_unk   = 1'b0;
    assign w_pred_unk = 1'b0;
`else
    assign w_lht_unk  = $isunknown(^LHTresult);
    assign w_lp_unk   = $isunknown(LPresult);
    assign w_pred_unk = $isunknown(PredictedBranch);
`endif

    assign w_pc_chg = r_vld && (PC != r_pc_q);
    assign w_ph_chg = r_vld && (PHresult != r_ph_q);
    assign w_fall   = r_vld && r_sc_q && !slowclock;
    assign w_rise   = r_vld && !r_sc_q && slowclock;

    always_comb begin
        w_det = '0;
        if (w_pc_chg && (r_win_st == c_win_hold) && (r_wcnt < c_pc_hold))
            w_det[0] = 1'b1;
        // A PC change abandons the known-checks of the window it ends.
        if (!w_pc_chg && (r_win_st == c_win_hold)) begin
            w_det[1] = (r_wcnt == c_lht_lat)  && w_lht_unk;
            w_det[2] = (r_wcnt == c_lp_lat)   && w_lp_unk;
            w_det[3] = (r_wcnt == c_pred_lat) && w_pred_unk;
        end
        if (w_ph_chg && (r_ph_st == c_win_hold) && (r_phcnt < c_ph_hold))
            w_det[4] = 1'b1;
        if (r_sc_st == c_sc_low) begin
            if (w_rise)
                w_det[5] = (r_lcnt != c_slow_lo);
            else if (r_lcnt == c_slow_lo)
                w_det[5] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld    <= 1'b0;
            r_pc_q   <= '0;
            r_ph_q   <= '0;
            r_sc_q   <= 1'b0;
            r_win_st <= c_win_idle;
            r_wcnt   <= '0;
            r_ph_st  <= c_win_idle;
            r_phcnt  <= '0;
            r_sc_st  <= c_sc_high;
            r_lcnt   <= '0;
        end else begin
            r_vld  <= 1'b1;
            r_pc_q <= PC;
            r_ph_q <= PHresult;
            r_sc_q <= slowclock;

            if (w_pc_chg) begin
                r_win_st <= c_win_hold;
                r_wcnt   <= 8'd1;
            end else if (r_win_st == c_win_hold) begin
                if (r_wcnt == c_pc_hold) r_win_st <= c_win_idle;
                else                     r_wcnt   <= r_wcnt + 8'd1;
            end

            if (w_ph_chg) begin
                r_ph_st <= c_win_hold;
                r_phcnt <= 8'd1;
            end else if (r_ph_st == c_win_hold) begin
                if (r_phcnt == c_ph_hold) r_ph_st <= c_win_idle;
                else                      r_phcnt <= r_phcnt + 8'd1;
            end

            case (r_sc_st)
                c_sc_high: if (w_fall) begin
                    r_sc_st <= c_sc_low;
                    r_lcnt  <= 8'd1;
                end
                c_sc_low: begin
                    if (w_rise)                  r_sc_st <= c_sc_high;
                    else if (r_lcnt == c_slow_lo) r_sc_st <= c_sc_wait;
                    else                         r_lcnt  <= r_lcnt + 8'd1;
                end
                c_sc_wait: if (w_rise) r_sc_st <= c_sc_high;
                default:   r_sc_st <= c_sc_high;
            endcase
        end
    end

    // Clear takes effect first so a same-cycle pulse is recorded afresh.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_pulse     <= '0;
            r_pulse_pc    <= '0;
            err_sticky    <= '0;
            err_count     <= '0;
            first_err_vec <= '0;
            first_err_pc  <= '0;
        end else begin
            err_pulse  <= mon_en ? w_det : 6'd0;
            r_pulse_pc <= PC;
            if (err_clear) begin
                err_sticky    <= err_pulse;
                err_count     <= (|err_pulse) ? CNT_W'(1) : '0;
                first_err_vec <= err_pulse;
                first_err_pc  <= (|err_pulse) ? r_pulse_pc : '0;
            end else begin
                err_sticky <= err_sticky | err_pulse;
                if ((|err_pulse) && (err_count != {CNT_W{1'b1}}))
                    err_count <= err_count + CNT_W'(1);
                if ((first_err_vec == 6'd0) && (|err_pulse)) begin
                    first_err_vec <= err_pulse;
                    first_err_pc  <= r_pulse_pc;
                end
            end
        end
    end

    assign err_any = |err_sticky;

`ifdef BPMON_PER_CHECK_CNT_EN
    for (genvar gi = 0; gi < 6; gi++) begin : g_chk_cnt
        always_ff @(posedge clock) begin
            if (reset || err_clear)
                chk_count[gi*CNT_W +: CNT_W] <= (!reset && err_pulse[gi]) ? CNT_W'(1) : '0;
            else if (err_pulse[gi] && (chk_count[gi*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
                chk_count[gi*CNT_W +: CNT_W] <= chk_count[gi*CNT_W +: CNT_W] + CNT_W'(1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_protocol_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_protocol_monitor
// Brief    : Directed self-checking bench for bp_protocol_monitor.
// Revision : 1.0
// ============================================================================
module tb_bp_protocol_monitor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mon_en = 1'b1;
    logic        err_clear = 1'b0;
    logic [9:0]  PC = 10'h000;
    logic        slowclock = 1'b1;
    logic [9:0]  LHTresult = 10'h000;
    logic        LPresult = 1'b0;
    logic        PredictedBranch = 1'b0;
    logic [11:0] PHresult = 12'h000;
    logic [5:0]  err_pulse;
    logic [5:0]  err_sticky;
    logic        err_any;
    logic [7:0]  err_count;
    logic [5:0]  first_err_vec;
    logic [9:0]  first_err_pc;

    int checks = 0;
    int passed = 0;
    logic four_state;
    logic xprobe;

    bp_protocol_monitor dut (
        .clock(clock), .reset(reset), .mon_en(mon_en), .err_clear(err_clear),
        .PC(PC), .slowclock(slowclock), .LHTresult(LHTresult),
        .LPresult(LPresult), .PredictedBranch(PredictedBranch),
        .PHresult(PHresult), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_any(err_any), .err_count(err_count),
        .first_err_vec(first_err_vec), .first_err_pc(first_err_pc)
    );

    always #5 clock = ~clock;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_errs();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
    endtask

    task automatic test_reset();
        step(2);
        checks++; if (err_pulse !== 6'd0) $display("FAIL rst_pulse: got %b want 000000", err_pulse); else passed++;
        checks++; if (err_sticky !== 6'd0 || err_any !== 1'b0) $display("FAIL rst_sticky: got %b/%b want 000000/0", err_sticky, err_any); else passed++;
        checks++; if (err_count !== 8'd0) $display("FAIL rst_count: got %0d want 0", err_count); else passed++;
        checks++; if (first_err_vec !== 6'd0 || first_err_pc !== 10'd0) $display("FAIL rst_first: got %b/%h want 000000/000", first_err_vec, first_err_pc); else passed++;
        reset = 1'b0;
        step(3);
    endtask

    task automatic test_pc_hold_ok();
        logic [5:0] acc;
        acc = '0;
        PC = 10'h010;
        for (int i = 0; i < 8; i++) begin step(); acc |= err_pulse; end
        PC = 10'h020;
        for (int i = 0; i < 12; i++) begin step(); acc |= err_pulse; end
        checks++; if (acc !== 6'd0) $display("FAIL pc_ok_pulse: got %b want 000000", acc); else passed++;
        checks++; if (err_count !== 8'd0) $display("FAIL pc_ok_count: got %0d want 0", err_count); else passed++;
    endtask

    task automatic test_pc_violation();
        PC = 10'h010;
        step(3);
        PC = 10'h011;
        step();
        checks++; if (err_pulse !== 6'b000001) $display("FAIL pc_viol_pulse: got %b want 000001", err_pulse); else passed++;
        step();
        checks++; if (err_pulse !== 6'd0) $display("FAIL pc_viol_once: got %b want 000000", err_pulse); else passed++;
        checks++; if (err_count !== 8'd1) $display("FAIL pc_viol_count: got %0d want 1", err_count); else passed++;
        checks++; if (first_err_pc !== 10'h011 || first_err_vec !== 6'b000001) $display("FAIL pc_viol_first: got %h/%b want 011/000001", first_err_pc, first_err_vec); else passed++;
        checks++; if (err_sticky !== 6'b000001 || err_any !== 1'b1) $display("FAIL pc_viol_sticky: got %b/%b want 000001/1", err_sticky, err_any); else passed++;
        step(10);
    endtask

    task automatic test_known();
        clear_errs();
        step(2);
        PC = 10'h030;
        step(2);
        LPresult = 1'bx;
        PredictedBranch = 1'bx;
        step();
        LPresult = 1'b0;
        PredictedBranch = 1'b0;
        checks++; if (err_pulse !== (four_state ? 6'b001100 : 6'b000000)) $display("FAIL known_pulse: got %b want %b", err_pulse, four_state ? 6'b001100 : 6'b000000); else passed++;
        step();
        checks++; if (err_count !== (four_state ? 8'd1 : 8'd0)) $display("FAIL known_count: got %0d want %0d", err_count, four_state ? 1 : 0); else passed++;
        step(10);
    endtask

    task automatic test_ph_and_clear();
        PHresult = 12'h001;
        step();
        checks++; if (err_pulse !== 6'd0) $display("FAIL ph_first_chg: got %b want 000000", err_pulse); else passed++;
        step();
        PHresult = 12'h002;
        step();
        checks++; if (err_pulse !== 6'd0) $display("FAIL ph_hold_ok: got %b want 000000", err_pulse); else passed++;
        PHresult = 12'h003;
        step();
        checks++; if (err_pulse !== 6'b010000) $display("FAIL ph_viol_pulse: got %b want 010000", err_pulse); else passed++;
        clear_errs();
        checks++; if (err_sticky !== 6'b010000) $display("FAIL clr_sticky: got %b want 010000", err_sticky); else passed++;
        checks++; if (err_count !== 8'd1) $display("FAIL clr_count: got %0d want 1", err_count); else passed++;
        checks++; if (first_err_vec !== 6'b010000) $display("FAIL clr_first: got %b want 010000", first_err_vec); else passed++;
        step(4);
    endtask

    task automatic test_slowclock();
        logic [5:0] acc;
        clear_errs();
        acc = '0;
        slowclock = 1'b0;
        step(); acc |= err_pulse;
        step(); acc |= err_pulse;
        slowclock = 1'b1;
        step(); acc |= err_pulse;
        step(2); acc |= err_pulse;
        checks++; if (acc !== 6'd0) $display("FAIL slow_exact: got %b want 000000", acc); else passed++;
        slowclock = 1'b0;
        step(2);
        step();
        checks++; if (err_pulse !== 6'b100000) $display("FAIL slow_long_pulse: got %b want 100000", err_pulse); else passed++;
        slowclock = 1'b1;
        step();
        checks++; if (err_pulse !== 6'd0) $display("FAIL slow_long_rise: got %b want 000000", err_pulse); else passed++;
        step(2);
        slowclock = 1'b0;
        step();
        slowclock = 1'b1;
        step();
        checks++; if (err_pulse !== 6'b100000) $display("FAIL slow_short: got %b want 100000", err_pulse); else passed++;
        step();
        checks++; if (err_count !== 8'd2) $display("FAIL slow_count: got %0d want 2", err_count); else passed++;
        step(3);
    endtask

    task automatic test_mon_en();
        mon_en = 1'b0;
        PC = 10'h040;
        step();
        PC = 10'h041;
        step();
        checks++; if (err_pulse !== 6'd0) $display("FAIL mon_off_pulse: got %b want 000000", err_pulse); else passed++;
        mon_en = 1'b1;
        PC = 10'h042;
        step();
        checks++; if (err_pulse !== 6'b000001) $display("FAIL mon_resume: got %b want 000001", err_pulse); else passed++;
        step();
        checks++; if (err_count !== 8'd3) $display("FAIL mon_count: got %0d want 3", err_count); else passed++;
        step(10);
    endtask

    task automatic test_saturate_and_reset();
        clear_errs();
        for (int i = 0; i < 300; i++) begin
            PC = PC ^ 10'h001;
            step();
        end
        checks++; if (err_count !== 8'hFF) $display("FAIL sat_count: got %h want ff", err_count); else passed++;
        PC = PC ^ 10'h001;
        step(2);
        checks++; if (err_count !== 8'hFF) $display("FAIL sat_hold: got %h want ff", err_count); else passed++;
        PC = PC ^ 10'h001;
        reset = 1'b1;
        step();
        checks++; if ({err_pulse, err_sticky, err_any, err_count, first_err_vec, first_err_pc} !== '0)
            $display("FAIL rst_mid: got %b %b %b %h %b %h want all zero", err_pulse, err_sticky, err_any, err_count, first_err_vec, first_err_pc);
        else passed++;
        reset = 1'b0;
        PC = PC ^ 10'h001;
        step();
        PC = PC ^ 10'h001;
        step(10);
        checks++; if (err_count !== 8'd0 || err_sticky !== 6'd0) $display("FAIL rst_abandon: got %0d/%b want 0/000000", err_count, err_sticky); else passed++;
    endtask

    initial begin
        xprobe = 1'bx;
        four_state = (xprobe === 1'bx);
        test_reset();
        test_pc_hold_ok();
        test_pc_violation();
        test_known();
        test_ph_and_clear();
        test_slowclock();
        test_mon_en();
        test_saturate_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
